// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared encodings for the LED sequencer.
//   MODE field values, FSM state codes and Avalon-MM register addresses.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'b00,
        MODE_BLINK   = 2'b01,
        MODE_SWEEP   = 2'b10,
        MODE_STATIC2 = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_ALARM = 2'b10
    } state_e;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/led_seq_if.sv
// led_seq_if: Avalon-MM slave bus of the LED sequencer.
//   address/chipselect/write_n/writedata driven by the master,
//   readdata returned combinationally by the slave.
interface led_seq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: period divider producing a one-cycle tick.
//   clk, reset_n : clock, asynchronous active-low reset
//   period       : cycles per tick (0 behaves as 1)
//   clear        : restart the count at 0 on the next edge
//   tick         : high while the count sits at period-1
module led_seq_prescaler #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] period,
    input  logic             clear,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = cnt == ((period == '0) ? '0 : period - CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= (clear || tick) ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: Avalon-MM LED pattern sequencer with alarm pre-emption.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (CTRL, PATTERN, PERIOD, STATUS)
//   alarm_req    : level request, takes the LEDs while high
//   alarm_ack    : registered grant, high while in ALARM
//   led_out      : registered LED drive
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    led_seq_if.slave         bus,
    input  logic             alarm_req,
    output logic             alarm_ack,
    output logic [WIDTH-1:0] led_out
);

    localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             en;
    mode_e            mode;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] period;
    state_e           state;
    state_e           state_nxt;
    logic             phase;
    logic [POS_W-1:0] pos;
    logic             wr;
    logic             wr_ctrl;
    logic             wr_period;
    logic             seq_clr;
    logic             presc_clr;
    logic             tick;
    logic             sweep_step;
    logic [WIDTH-1:0] target;
    logic             unused_wd;

    assign wr        = bus.chipselect && !bus.write_n;
    assign wr_ctrl   = wr && bus.address == ADDR_CTRL;
    assign wr_period = wr && bus.address == ADDR_PERIOD;
    assign unused_wd = ^bus.writedata;

    led_seq_prescaler #(.CNT_W(CNT_W)) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period),
        .clear   (presc_clr),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en      <= 1'b0;
            mode    <= MODE_STATIC;
            pattern <= '0;
            period  <= '0;
        end else if (wr) begin
            case (bus.address)
                ADDR_CTRL: begin
                    en   <= bus.writedata[0];
                    mode <= mode_e'(bus.writedata[2:1]);
                end
                ADDR_PATTERN: pattern <= bus.writedata[WIDTH-1:0];
                ADDR_PERIOD:  period  <= bus.writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Next state depends only on registered EN, so a CTRL write landing in the
    // same cycle as alarm_req cannot keep the FSM out of ALARM.
    always_comb begin
        state_nxt  = state;
        seq_clr    = 1'b0;
        presc_clr  = 1'b0;
        sweep_step = 1'b0;
        target     = '0;
        state_nxt  = alarm_req ? ST_ALARM : (en ? ST_RUN : ST_IDLE);
        seq_clr    = (state_nxt != state) ||
                     (state == ST_RUN && wr_ctrl && bus.writedata[2:1] != mode);
        presc_clr  = wr_ctrl || wr_period || (state_nxt != state);
        sweep_step = tick && state == ST_RUN && mode == MODE_SWEEP;
        case (state)
            ST_ALARM: target = phase ? '0 : '1;
            ST_RUN:   target = (mode == MODE_BLINK) ? (phase ? '0 : pattern) :
                               (mode == MODE_SWEEP) ? WIDTH'(1) << pos : pattern;
            default:  target = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            phase     <= 1'b0;
            pos       <= '0;
            led_out   <= '0;
            alarm_ack <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= seq_clr ? 1'b0 : phase ^ tick;
            pos       <= seq_clr ? '0 :
                         !sweep_step ? pos :
                         (pos == POS_W'(WIDTH - 1)) ? '0 : pos + POS_W'(1);
            led_out   <= target;
            alarm_ack <= state == ST_ALARM;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_CTRL:    bus.readdata = {29'd0, mode, en};
            ADDR_PATTERN: bus.readdata = 32'(pattern);
            ADDR_PERIOD:  bus.readdata = 32'(period);
            ADDR_STATUS:  bus.readdata = 32'({led_out, 1'b0, state, alarm_ack});
        endcase
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed self-checking bench for led_seq_ctrl.
module tb_led_seq_ctrl;

    logic       clk;
    logic       reset_n;
    logic       alarm_req;
    logic       alarm_ack;
    logic [9:0] led_out;
    int         checks;
    int         errors;

    led_seq_if bus ();

    led_seq_ctrl #(.WIDTH(10), .CNT_W(24)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .alarm_req (alarm_req),
        .alarm_ack (alarm_ack),
        .led_out   (led_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (observed running, expected finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    // Returns on the falling edge right after the capturing rising edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    logic [9:0] alarm_led [15];
    logic       alarm_ak  [15];

    initial begin
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        alarm_req      = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        // Alarm window with PERIOD=3: ack one cycle after entry, toggle every 3.
        alarm_led = '{10'h000, 10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000,
                      10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 10'h001, 10'h001, 10'h001, 10'h002};
        alarm_ak  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                      1'b0, 1'b0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_ack", 32'(alarm_ack), 32'h0);
        rd_chk("rst_status", 2'd3, 32'h0);
        reset_n = 1'b1;

        wr(2'd3, 32'hFFFF_FFFF);
        rd_chk("status_wr_ctrl", 2'd0, 32'h0);
        rd_chk("status_wr_pat", 2'd1, 32'h0);

        // Static pattern: led two cycles after the CTRL write.
        wr(2'd1, 32'h2A5);
        wr(2'd0, 32'h1);
        chk("static_n1_led", 32'(led_out), 32'h0);
        rd_chk("static_n1_status", 2'd3, 32'h0);
        @(negedge clk);
        chk("static_n2_led", 32'(led_out), 32'h0);
        rd_chk("static_n2_status", 2'd3, 32'h2);
        @(negedge clk);
        chk("static_n3_led", 32'(led_out), 32'h2A5);
        rd_chk("static_status", 2'd3, 32'h2A52);
        rd_chk("static_ctrl", 2'd0, 32'h1);
        wr(2'd1, 32'h155);
        chk("track_n1_led", 32'(led_out), 32'h2A5);
        @(negedge clk);
        chk("track_n2_led", 32'(led_out), 32'h155);

        // Blink, PERIOD=4.
        wr(2'd1, 32'h00F);
        wr(2'd2, 32'h4);
        wr(2'd0, 32'h3);
        rd_chk("blink_period", 2'd2, 32'h4);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            chk($sformatf("blink_n%0d", n), 32'(led_out), (((n - 1) / 4) % 2 == 0) ? 32'h00F : 32'h0);
        end

        // Sweep, PERIOD=2.
        wr(2'd2, 32'h2);
        wr(2'd0, 32'h5);
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            chk($sformatf("sweep_n%0d", n), 32'(led_out), 32'(1) << (((n - 1) / 2) % 10));
        end

        // Alarm for 10 cycles over a running sweep, PERIOD=3.
        wr(2'd2, 32'h3);
        alarm_req   = 1'b1;
        bus.address = 2'd3;
        for (int n = 0; n <= 14; n++) begin
            @(negedge clk);
            chk($sformatf("alarm_ack_n%0d", n), 32'(alarm_ack), 32'(alarm_ak[n]));
            if (n >= 1)
                chk($sformatf("alarm_led_n%0d", n), 32'(led_out), 32'(alarm_led[n]));
            if (n == 5)
                rd_chk("alarm_status_n5", 2'd3, 32'h5);
            if (n == 8)
                rd_chk("alarm_status_n8", 2'd3, 32'h3FF5);
            if (n == 9)
                alarm_req = 1'b0;
        end

        // Alarm raised together with a CTRL=0 write.
        @(negedge clk);
        bus.address    = 2'd0;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = 32'h0;
        alarm_req      = 1'b1;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd3;
        #1;
        chk("both_state", 32'(bus.readdata[2:1]), 32'h2);
        @(negedge clk);
        chk("both_n1_ack", 32'(alarm_ack), 32'h1);
        chk("both_n1_led", 32'(led_out), 32'h3FF);
        @(negedge clk);
        alarm_req = 1'b0;
        @(negedge clk);
        rd_chk("both_n3_status", 2'd3, 32'h3FF1);
        @(negedge clk);
        chk("both_n4_led", 32'(led_out), 32'h0);
        chk("both_n4_ack", 32'(alarm_ack), 32'h0);
        rd_chk("both_ctrl", 2'd0, 32'h0);

        // Reset pulse in the middle of ALARM.
        @(negedge clk);
        alarm_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_ack", 32'(alarm_ack), 32'h1);
        chk("pre_rst_led", 32'(led_out), 32'h3FF);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_out), 32'h0);
        chk("async_rst_ack", 32'(alarm_ack), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd_chk("rearm_status", 2'd3, 32'h4);
        rd_chk("rearm_pattern", 2'd1, 32'h0);
        @(negedge clk);
        chk("rearm_ack", 32'(alarm_ack), 32'h1);
        rd_chk("rearm_status2", 2'd3, 32'h3FF5);
        alarm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rearm_exit_led", 32'(led_out), 32'h0);
        chk("rearm_exit_ack", 32'(alarm_ack), 32'h0);

        // Undefined bits read as zero; MODE=11 behaves as static.
        wr(2'd0, 32'hFFFF_FFF8);
        rd_chk("ctrl_undef", 2'd0, 32'h0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd_chk("pattern_undef", 2'd1, 32'h3FF);
        wr(2'd2, 32'hFFFF_FFFF);
        rd_chk("period_undef", 2'd2, 32'hFF_FFFF);
        wr(2'd1, 32'h0C3);
        wr(2'd0, 32'h7);
        @(negedge clk);
        @(negedge clk);
        chk("mode3_led", 32'(led_out), 32'h0C3);
        rd_chk("mode3_ctrl", 2'd0, 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
